sd_spi_host: RTL and testbench
==============================

// Module: sd_spi_host
// PURPOSE
//  SPI-mode host master that sits directly upstream of the SD card SPI slave.
//  Takes a 48-bit command word over a valid/ready handshake and drives cs_n/sclk/mosi.
//  Captures the card's miso reply and returns it as 48-bit response frames.
//  Frame count: 1 frame for ordinary commands; 3 frames (R1, token, data) for CMD17 (opcode byte 8'h51).
// PARAMETERS
//  HALF_PERIOD  4  clk cycles per sclk half-period; legal >=3 (miso is sampled 2 clk after each fall)
//  CS_SETUP     4  clk cycles from cs_n low to the first sclk rise; legal >=2
//  CS_GAP       4  clk cycles cs_n is held high after a transaction before cmd_ready re-asserts
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous active-high reset
//  cmd_data   in   48  command frame, MSB transmitted first
//  cmd_valid  in   1   command offered
//  cmd_ready  out  1   host idle; accepts cmd_data when cmd_valid&&cmd_ready
//  rsp_data   out  48  last completed response frame, first received bit in [47]
//  rsp_valid  out  1   1-clk pulse per completed frame
//  rsp_last   out  1   qualifies rsp_valid; high on the final frame of a command
//  busy       out  1   transaction in progress (not IDLE)
//  cs_n       out  1   card select, active low
//  sclk       out  1   SPI clock, idle low (mode 0)
//  mosi       out  1   host->card data
//  miso       in   1   card->host data
// BEHAVIOUR
//  Clock/reset: one clock (clk); reset (rst) is asynchronous and active-high.
//  Reset values: cs_n=1, sclk=0, mosi=1, cmd_ready=1, busy=0, rsp_valid=0, rsp_last=0, rsp_data=0.
//  Reset mid-transaction: all outputs return to reset values immediately; any partial frame is dropped, no rsp_valid.
//  All outputs are registered.
//  FSM IDLE -> SETUP -> SCK_HI <-> SCK_LO -> GAP -> IDLE.
//  IDLE:
//   - cmd_ready=1.
//   - On handshake: latch cmd, set F=3 if cmd[47:40]==8'h51 else F=1.
//   - Same edge: cs_n<=0, mosi<=cmd[47], cmd_ready<=0, busy<=1; go to SETUP.
//  SETUP: hold CS_SETUP clk, then sclk<=1 and go to SCK_HI.
//  sclk cycles:
//   - Index k runs from 0 to N-1, with N = 47+48*F (95 for F=1, 191 for F=3).
//   - Each half-phase lasts HALF_PERIOD clk; SCK_HI ends with sclk<=0, SCK_LO ends with sclk<=1.
//   - On fall k with k<47: mosi<=cmd[46-k].
//   - On fall 47 and later: mosi<=1.
//  Response sampling:
//   - Response bit j (j = 0..48F-1) is driven by the card after fall 47+j.
//   - Host samples it exactly 2 clk after the edge that drove fall 47+j.
//   - Sampled bit is shifted into the rsp shift register, MSB first.
//  Frames:
//   - Every 48th sampled bit: rsp_data<=frame, rsp_valid<=1 for 1 clk.
//   - rsp_last=1 on frame F, else 0.
//   - rsp_data holds until the next frame.
//  End of transaction:
//   - The sample edge of bit 48F-1 also sets cs_n<=1, mosi<=1 and enters GAP; no further sclk edges.
//   - GAP: hold CS_GAP clk, then go to IDLE with cmd_ready<=1 and busy<=0.
//   - cmd_valid during busy/GAP is ignored (not consumed).
//  Counters:
//   - sclk cycle counter is 8 bits (max 191).
//   - Phase counter counts HALF_PERIOD-1 down to 0.
//   - Frame bit counter wraps from 47 to 0.
//  miso is not inspected for content; the host never aborts early.
// TESTING
//  - CMD0 48'h400000000095 -> one frame 48'h000000000001, rsp_last=1; 95 sclk rises; mosi bits at rises 0..47 equal the cmd.
//  - CMD8 48'h48000001AA87 -> 48'h00000001AA87; ACMD41 48'h694000000077 -> 48'h000000000000.
//  - CMD17 48'h5100000000FF -> frames 48'h000000000000, 48'h0000000000FE, 48'hDEADBEEF1234; rsp_last only on the 3rd; 191 rises.
//  - Unknown 48'h123456789ABC -> 48'hFFFFFFFFFFFF (last bit valid, proves 2-clk sample point).
//  - cmd_valid held high with CMD0 then CMD58 -> second accepted only after cs_n high >=CS_GAP clk; no dropped or duplicated command.
//  - rst pulsed at sclk rise 30 of CMD0 -> outputs at reset values, no rsp_valid; a following CMD0 returns 48'h000000000001.

Source files
------------

// File: rtl/sd_spi_host.sv
// SPI-mode SD host master: shifts a 48-bit command out on mosi and
// returns the card's miso reply as one or three 48-bit frames.
module sd_spi_host #(
  parameter int HALF_PERIOD = 4,
  parameter int CS_SETUP    = 4,
  parameter int CS_GAP      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [47:0] rsp_data,
  output logic        rsp_valid,
  output logic        rsp_last,
  output logic        busy,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  localparam int M1   = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
  localparam int MAXC = (M1 > CS_GAP) ? M1 : CS_GAP;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] SETUP_LD  = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HALF_LD   = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LD    = CW'(CS_GAP - 1);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(HALF_PERIOD - 2);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    cyc_q, cyc_d;
  logic [5:0]    bit_q, bit_d;
  logic [1:0]    frm_q, frm_d;
  logic [1:0]    nfrm_q, nfrm_d;
  logic [46:0]   tx_q, tx_d;
  logic [46:0]   rx_q, rx_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic [47:0]   rsp_data_q, rsp_data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_last_q, rsp_last_d;

  logic [7:0] last_cyc;
  logic       sample;

  // Final fall index is 46 + 48*F.
  assign last_cyc = (nfrm_q == 2'd3) ? 8'd190 : 8'd94;
  assign sample   = (cyc_q >= 8'd47) && (cnt_q == SAMPLE_AT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    frm_d       = frm_q;
    nfrm_d      = nfrm_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          tx_d    = cmd_data[46:0];
          nfrm_d  = (cmd_data[47:40] == 8'h51) ? 2'd3 : 2'd1;
          cs_n_d  = 1'b0;
          mosi_d  = cmd_data[47];
          ready_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = SETUP_LD;
          cyc_d   = 8'd0;
          bit_d   = 6'd0;
          frm_d   = 2'd0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (cnt_q == '0) begin
          sclk_d  = 1'b1;
          cnt_d   = HALF_LD;
          state_d = SCK_HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      SCK_HI: begin
        if (cnt_q == '0) begin
          // Ones shift in behind the command, so mosi idles high after bit 0.
          sclk_d  = 1'b0;
          mosi_d  = tx_q[46];
          tx_d    = {tx_q[45:0], 1'b1};
          cnt_d   = HALF_LD;
          state_d = SCK_LO;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      SCK_LO: begin
        if (sample) begin
          rx_d  = {rx_q[45:0], miso};
          bit_d = (bit_q == 6'd47) ? 6'd0 : bit_q + 6'd1;
          if (bit_q == 6'd47) begin
            rsp_data_d  = {rx_q, miso};
            rsp_valid_d = 1'b1;
            rsp_last_d  = (frm_q + 2'd1) == nfrm_q;
            frm_d       = frm_q + 2'd1;
          end
        end
        if (sample && (cyc_q == last_cyc)) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b1;
          cnt_d   = GAP_LD;
          state_d = GAP;
        end else if (cnt_q == '0) begin
          sclk_d  = 1'b1;
          cyc_d   = cyc_q + 8'd1;
          cnt_d   = HALF_LD;
          state_d = SCK_HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      GAP: begin
        if (cnt_q == '0) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cyc_q       <= '0;
      bit_q       <= '0;
      frm_q       <= '0;
      nfrm_q      <= 2'd1;
      tx_q        <= '0;
      rx_q        <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      frm_q       <= frm_d;
      nfrm_q      <= nfrm_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign cs_n      = cs_n_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_sd_spi_host.sv
// Bench for sd_spi_host: a behavioural SD card answers on miso and
// every frame, mosi bit, sclk count and cs_n gap is checked.
module tb_sd_spi_host;

  localparam int HP  = 4;
  localparam int CSS = 4;
  localparam int CSG = 4;

  logic        clk;
  logic        rst;
  logic [47:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [47:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_last;
  logic        busy;
  logic        cs_n;
  logic        sclk;
  logic        mosi;
  logic        miso;

  int n_cmp = 0;
  int n_bad = 0;

  sd_spi_host #(
    .HALF_PERIOD(HP),
    .CS_SETUP   (CSS),
    .CS_GAP     (CSG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_data (cmd_data),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .rsp_data (rsp_data),
    .rsp_valid(rsp_valid),
    .rsp_last (rsp_last),
    .busy     (busy),
    .cs_n     (cs_n),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Card reply stream, first frame in [143:96].
  function automatic logic [143:0] resp_of(input logic [47:0] c);
    case (c[47:40])
      8'h40:   return {48'h000000000001, 96'h0};
      8'h48:   return {16'h0000, c[31:0], 96'h0};
      8'h69:   return {48'h000000000000, 96'h0};
      8'h7A:   return {48'h0000C0FF8000, 96'h0};
      8'h51:   return {48'h000000000000, 48'h0000000000FE,
                       48'hDEADBEEF1234};
      default: return {144{1'b1}};
    endcase
  endfunction

  function automatic int frames_of(input logic [47:0] c);
    return (c[47:40] == 8'h51) ? 3 : 1;
  endfunction

  // Card: drives reply bit j only from 1.5 to 2.5 clk after fall 47+j,
  // and its complement otherwise, so only the exact sample point works.
  logic         prev_sclk;
  int           c_rise, c_fall, c_dly;
  logic [47:0]  c_cmd;
  logic [143:0] c_stream;
  logic         c_bit;

  always @(negedge clk) begin
    if (cs_n !== 1'b0) begin
      c_rise = 0;
      c_fall = 0;
      c_dly = 0;
      prev_sclk = 1'b0;
      miso = 1'b1;
    end else begin
      if (c_dly == 1) begin
        miso = c_bit;
        c_dly = 2;
      end else if (c_dly == 2) begin
        miso = ~c_bit;
        c_dly = 0;
      end
      if (sclk && !prev_sclk) begin
        if (c_rise < 48) c_cmd = {c_cmd[46:0], mosi};
        c_rise++;
        if (c_rise == 48) c_stream = resp_of(c_cmd);
      end
      if (!sclk && prev_sclk) begin
        if (c_fall >= 47 && c_fall - 47 < 144) begin
          c_bit = c_stream[143 - (c_fall - 47)];
          c_dly = 1;
        end
        c_fall++;
      end
      prev_sclk = sclk;
    end
  end

  int          mon_rises = 0;
  int          n_txn = 0;
  logic [47:0] mon_cmd = '0;

  always @(posedge sclk or negedge cs_n) begin
    if (sclk) begin
      if (mon_rises < 48) mon_cmd = {mon_cmd[46:0], mosi};
      mon_rises++;
    end else begin
      mon_rises = 0;
      mon_cmd = '0;
      n_txn++;
    end
  end

  int rsp_cnt = 0;
  int hi_run = 0;
  int last_gap = 0;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) rsp_cnt++;
    if (cs_n === 1'b1) hi_run++;
    else if (hi_run > 0) begin
      last_gap = hi_run;
      hi_run = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", 64'(t < 5000), 64'(1));
  endtask

  task automatic get_frames(input logic [47:0] c);
    logic [143:0] want;
    int f, t;
    want = resp_of(c);
    f = frames_of(c);
    for (int i = 0; i < f; i++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (rsp_valid !== 1'b1 && t < 3000);
      check($sformatf("frame%0d_wait", i), 64'(t < 3000), 64'(1));
      check($sformatf("frame%0d", i), 64'(rsp_data),
            64'(want[143 - 48*i -: 48]));
      check($sformatf("last%0d", i), 64'(rsp_last), 64'(i == f - 1));
    end
  endtask

  task automatic do_cmd(input logic [47:0] c);
    int r0, f;
    f = frames_of(c);
    @(negedge clk);
    wait_ready();
    cmd_data = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    r0 = rsp_cnt;
    check("start_csn", 64'(cs_n), 64'(0));
    check("start_busy", 64'(busy), 64'(1));
    check("start_rdy", 64'(cmd_ready), 64'(0));
    check("start_mosi", 64'(mosi), 64'(c[47]));
    get_frames(c);
    @(posedge clk);
    #1;
    check("rises", 64'(mon_rises), 64'(47 + 48*f));
    check("mosi_cmd", 64'(mon_cmd), 64'(c));
    check("end_csn", 64'(cs_n), 64'(1));
    check("n_rsp", 64'(rsp_cnt - r0), 64'(f));
  endtask

  logic [47:0] c;
  logic [7:0]  op;
  int          sel, r0, n0, t;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_csn", 64'(cs_n), 64'(1));
    check("rst_sclk", 64'(sclk), 64'(0));
    check("rst_mosi", 64'(mosi), 64'(1));
    check("rst_rdy", 64'(cmd_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rv", 64'(rsp_valid), 64'(0));
    check("rst_rl", 64'(rsp_last), 64'(0));
    check("rst_rd", 64'(rsp_data), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    do_cmd(48'h400000000095);
    do_cmd(48'h48000001AA87);
    do_cmd(48'h694000000077);
    do_cmd(48'h5100000000FF);
    do_cmd(48'h123456789ABC);

    // cmd_valid held across CMD0 then CMD58.
    @(negedge clk);
    wait_ready();
    n0 = n_txn;
    cmd_data = 48'h400000000095;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_data = 48'h7A0000000000;
    get_frames(48'h400000000095);
    t = 0;
    while (cs_n !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    cmd_valid = 1'b0;
    check("b2b_wait", 64'(t < 100), 64'(1));
    get_frames(48'h7A0000000000);
    @(posedge clk);
    #1;
    check("b2b_gap", 64'(last_gap), 64'(CSG + 1));
    check("b2b_cmd", 64'(mon_cmd), 64'(48'h7A0000000000));
    repeat (50) @(posedge clk);
    #1;
    check("b2b_ntxn", 64'(n_txn - n0), 64'(2));

    // Reset around sclk rise 30 of CMD0.
    @(negedge clk);
    wait_ready();
    cmd_data = 48'h400000000095;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    r0 = rsp_cnt;
    t = 0;
    while (mon_rises < 31 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("mid_wait", 64'(t < 2000), 64'(1));
    #1;
    rst = 1'b1;
    #1;
    check("mid_csn", 64'(cs_n), 64'(1));
    check("mid_sclk", 64'(sclk), 64'(0));
    check("mid_mosi", 64'(mosi), 64'(1));
    check("mid_rdy", 64'(cmd_ready), 64'(1));
    check("mid_busy", 64'(busy), 64'(0));
    check("mid_rd", 64'(rsp_data), 64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    check("mid_norsp", 64'(rsp_cnt - r0), 64'(0));
    check("mid_idle_csn", 64'(cs_n), 64'(1));
    do_cmd(48'h400000000095);

    for (int n = 0; n < 8; n++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       op = 8'h40;
        1:       op = 8'h48;
        2:       op = 8'h69;
        3:       op = 8'h7A;
        4:       op = 8'h51;
        default: op = 8'($urandom);
      endcase
      c = {op, 32'($urandom), 8'($urandom)};
      do_cmd(c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
